fifo_axi: RTL and testbench

Synchronous single-clock FIFO with AXI-Stream-style valid/ready handshakes on both sides. The upstream producer pushes words through the slave port (s_*), and the downstream consumer pops them through the master port (m_*). Output is first-word-fall-through. The block is a generic elastic buffer between stream stages inside one clock domain.

---
 rtl/fifo_axi_mem.sv | 30 +++
 rtl/fifo_axi.sv | 68 ++++++
 tb/tb_fifo_axi.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_axi_mem.sv
// fifo_axi_mem: register-array storage for fifo_axi.
//   aclk   - write clock (rising edge)
//   we     - write enable, one word per cycle
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - asynchronous read data, mem[raddr]
// Contents are deliberately not reset; the pointers in the parent decide
// which entries hold live words.
module fifo_axi_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_axi.sv
// fifo_axi: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides.
//   aclk, aresetn    - clock, synchronous active-low reset
//   s_data/s_valid   - producer word and its valid
//   s_ready          - FIFO not full
//   m_data/m_valid   - head word (0 when empty) and not-empty flag
//   m_ready          - consumer takes m_data this cycle
// s_ready and m_valid come only from registered pointers, so there is no
// combinational path from s_valid/m_ready to them.
module fifo_axi #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    // Extra MSB on each pointer is a wrap bit: it distinguishes full from
    // empty when the address bits match.
    logic [ADDR_W:0]       wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] rdata;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign s_ready = !full;
    assign m_valid = !empty;

    // Full blocks pushes even when a pop happens the same cycle: no pass-through.
    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    fifo_axi_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .aclk  (aclk),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (s_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Stale storage must not leak out while empty.
    assign m_data = empty ? '0 : rdata;

endmodule

// File: tb/tb_fifo_axi.sv
module tb_fifo_axi;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: a plain queue of live words
    logic [DW-1:0] q[$];
    int  n_push = 0;
    int  n_pop  = 0;
    bit  armed  = 0;

    fifo_axi #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model update on each rising edge, from the handshake rules alone.
    initial begin
        forever begin
            @(posedge aclk);
            if (!aresetn) begin
                q.delete();
                armed = 1;
            end else if (armed) begin
                bit do_pop, do_push;
                do_pop  = m_ready && (q.size() > 0);
                do_push = s_valid && (q.size() < DEPTH);
                if (do_pop)  begin void'(q.pop_front()); n_pop++;  end
                if (do_push) begin q.push_back(s_data);  n_push++; end
            end
        end
    end

    // Continuous output check mid-cycle.
    initial begin
        forever begin
            @(negedge aclk);
            if (armed) begin
                chk("s_ready", s_ready, (q.size() < DEPTH));
                chk("m_valid", m_valid, (q.size() > 0));
                chk("m_data",  m_data,  (q.size() > 0) ? q[0] : '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // One cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        aresetn = 1'b0;
        repeat (cycles) drive(1'b0, '0, 1'b0);
        aresetn = 1'b1;
    endtask

    initial begin
        int p0, n0, t;
        logic acc;
        aresetn = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(posedge aclk);
        #1;

        // 1. reset
        do_reset(2);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data,  0);
        drive(1'b0, '0, 1'b0);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_m_valid", m_valid, 0);

        // 2. fill, one push every two cycles
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'hA000_0000 + i, 1'b0);
            drive(1'b0, '0, 1'b0);
            chk("fill_s_ready", s_ready, (i < DEPTH - 1));
        end
        n0 = n_push;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, '0, 1'b0);
        chk("ovf_ignored", n_push, n0);
        chk("ovf_head", m_data, 32'hA000_0000);

        // 3. drain, one pop every two cycles
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", m_data, 32'hA000_0000 + i);
            drive(1'b0, '0, 1'b1);
            drive(1'b0, '0, 1'b0);
        end
        chk("drained_m_valid", m_valid, 0);
        p0 = n_pop;
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        chk("underflow_ignored", n_pop, p0);
        chk("drained_m_data", m_data, 0);

        // 4. concurrent producer / consumer
        n0 = n_push;
        p0 = n_pop;
        s_valid = 1'b0;
        m_ready = 1'b0;
        fork
            begin : writer
                repeat (2) begin @(posedge aclk); #1; end
                for (int w = 0; w < 31; w++) begin
                    s_valid = 1'b1;
                    s_data  = $urandom;
                    t = 0;
                    do begin
                        @(negedge aclk);
                        acc = s_ready;
                        @(posedge aclk);
                        #1;
                        t++;
                    end while (!acc && t < 200);
                    chk("wr_accept", acc, 1);
                    s_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                end
            end
            begin : reader
                for (int r = 0; r < 32; r++) begin
                    m_ready = 1'b1;
                    @(posedge aclk);
                    #1;
                    m_ready = 1'b0;
                    if (r == 0) chk("empty_pop_ignored", m_valid, 0);
                    repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
                end
            end
        join
        t = 0;
        m_ready = 1'b1;
        while (m_valid && t < 64) begin @(posedge aclk); #1; t++; end
        m_ready = 1'b0;
        chk("conc_drain_timeout", (t < 64), 1);
        chk("conc_pushes", n_push - n0, 31);
        chk("conc_pops",   n_pop - p0, 31);

        // 5. full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'hB000_0000 + i, 1'b0);
        chk("full_s_ready", s_ready, 0);
        n0 = n_push;
        drive(1'b1, 32'h0BAD_0BAD, 1'b1);
        chk("fullpop_push_rejected", n_push, n0);
        chk("fullpop_s_ready", s_ready, 1);
        chk("fullpop_head", m_data, 32'hB000_0001);
        drive(1'b1, 32'hB000_0010, 1'b0);
        chk("refill_s_ready", s_ready, 0);

        // 6. mid-operation reset, then traffic across pointer wraps
        do_reset(1);
        chk("rst2_m_valid", m_valid, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hC000_0000 + i, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        chk("pre_rst_head", m_data, 32'hC000_0003);
        do_reset(1);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_data",  m_data,  0);
        n0 = n_push;
        t  = 0;
        while ((n_push - n0) < 40 && t < 2000) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
            t++;
        end
        s_valid = 1'b0;
        t = 0;
        m_ready = 1'b1;
        while (m_valid && t < 64) begin @(posedge aclk); #1; t++; end
        m_ready = 1'b0;
        chk("wrap_pushes", n_push - n0, 40);
        chk("wrap_empty", m_valid, 0);

        drive(1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
